// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine blocks: coin codes, coin values
// in the 100-unit money scale, and the change dispenser state encoding.
package vending_pkg;

    localparam int DEFAULT_AMOUNT_W = 16;
    localparam int DEFAULT_COUNT_W  = 4;

    typedef enum logic [1:0] {
        COIN_500  = 2'b00,
        COIN_1000 = 2'b01,
        COIN_2000 = 2'b10,
        COIN_5000 = 2'b11
    } coin_code_t;

    localparam int VALUE_500  = 5;
    localparam int VALUE_1000 = 10;
    localparam int VALUE_2000 = 20;
    localparam int VALUE_5000 = 50;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAN = 3'd1,
        EMIT = 3'd2,
        DONE = 3'd3,
        FAIL = 3'd4
    } dispenser_state_t;

    // Money value of one coin of the given denomination code.
    function automatic logic [7:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_500:  coin_value = 8'(VALUE_500);
            COIN_1000: coin_value = 8'(VALUE_1000);
            COIN_2000: coin_value = 8'(VALUE_2000);
            default:   coin_value = 8'(VALUE_5000);
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser.sv
// Change dispenser: on a purchase commit, computes change, plans a greedy
// coin breakdown limited by the coins on hand, and hands the coins one by one
// to the coin-return mechanism over a valid/ready handshake. If exact change
// cannot be made, nothing is emitted and the request ends with an error pulse.
module change_dispenser
    import vending_pkg::*;
#(
    parameter int AMOUNT_W = DEFAULT_AMOUNT_W,
    parameter int COUNT_W  = DEFAULT_COUNT_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] total_money,
    input  logic [AMOUNT_W-1:0] total_price,
    input  logic [COUNT_W-1:0]  count_500,
    input  logic [COUNT_W-1:0]  count_1000,
    input  logic [COUNT_W-1:0]  count_2000,
    input  logic [COUNT_W-1:0]  count_5000,
    input  logic                coin_ready,
    output logic                coin_valid,
    output logic [1:0]          coin_out,
    output logic [AMOUNT_W-1:0] change_amount,
    output logic                busy,
    output logic                done,
    output logic                error
);

    localparam int TOTAL_W = COUNT_W + 2;

    dispenser_state_t    state_q;
    logic [AMOUNT_W-1:0] remaining_q;
    logic [AMOUNT_W-1:0] change_q;
    logic [COUNT_W-1:0]  stock_q [4];
    logic [COUNT_W-1:0]  plan_q  [4];
    logic [1:0]          idx_q;
    logic                coin_valid_q;
    logic                busy_q;
    logic                done_q;
    logic                error_q;

    logic [1:0]          emit_code;
    logic [TOTAL_W-1:0]  plan_total;
    logic [AMOUNT_W-1:0] idx_value;

    // Value of the denomination currently being considered by the planner.
    always_comb begin
        idx_value = AMOUNT_W'(coin_value(idx_q));
    end

    // Largest denomination still owed, and how many coins remain in the plan.
    always_comb begin
        emit_code  = COIN_500;
        plan_total = '0;
        for (int i = 0; i < 4; i++) begin
            plan_total = plan_total + TOTAL_W'(plan_q[i]);
            if (plan_q[i] != '0) begin
                emit_code = 2'(i);
            end
        end
    end

    // Request sequencing: latch, plan one coin or step per cycle, emit, finish.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            change_q     <= '0;
            idx_q        <= '0;
            coin_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                stock_q[i] <= '0;
                plan_q[i]  <= '0;
            end
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (total_money >= total_price) begin
                            change_q    <= total_money - total_price;
                            remaining_q <= total_money - total_price;
                            stock_q[0]  <= count_500;
                            stock_q[1]  <= count_1000;
                            stock_q[2]  <= count_2000;
                            stock_q[3]  <= count_5000;
                            for (int i = 0; i < 4; i++) begin
                                plan_q[i] <= '0;
                            end
                            idx_q   <= 2'd3;
                            state_q <= PLAN;
                        end else begin
                            change_q <= '0;
                            done_q   <= 1'b1;
                            error_q  <= 1'b1;
                            state_q  <= FAIL;
                        end
                    end
                end
                PLAN: begin
                    if (remaining_q >= idx_value && stock_q[idx_q] != '0) begin
                        plan_q[idx_q]  <= plan_q[idx_q] + COUNT_W'(1);
                        stock_q[idx_q] <= stock_q[idx_q] - COUNT_W'(1);
                        remaining_q    <= remaining_q - idx_value;
                    end else if (idx_q != 2'd0) begin
                        idx_q <= idx_q - 2'd1;
                    end else if (remaining_q == '0) begin
                        if (plan_total == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            coin_valid_q <= 1'b1;
                            state_q      <= EMIT;
                        end
                    end else begin
                        for (int i = 0; i < 4; i++) begin
                            plan_q[i] <= '0;
                        end
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        state_q <= FAIL;
                    end
                end
                EMIT: begin
                    if (coin_ready) begin
                        plan_q[emit_code] <= plan_q[emit_code] - COUNT_W'(1);
                        if (plan_total == TOTAL_W'(1)) begin
                            coin_valid_q <= 1'b0;
                            done_q       <= 1'b1;
                            state_q      <= DONE;
                        end
                    end
                end
                DONE, FAIL: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    coin_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    assign coin_valid    = coin_valid_q;
    assign coin_out      = emit_code;
    assign change_amount = change_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: a table of hand-derived transactions, a few
// multi-cycle corner sequences, and randomized requests checked against a
// greedy change-making reference model.
module tb_change_dispenser;

    typedef struct {
        logic [15:0]  money;
        logic [15:0]  price;
        logic [3:0]   c0;
        logic [3:0]   c1;
        logic [3:0]   c2;
        logic [3:0]   c3;
        logic [15:0]  expChange;
        bit           expFail;
        logic [127:0] expCoins;
        int           expCount;
        int           expLatency;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] total_money;
    logic [15:0] total_price;
    logic [3:0]  count_500;
    logic [3:0]  count_1000;
    logic [3:0]  count_2000;
    logic [3:0]  count_5000;
    logic        coin_ready;
    logic        coin_valid;
    logic [1:0]  coin_out;
    logic [15:0] change_amount;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int passes = 0;

    vec_t vecs[8];

    change_dispenser #(.AMOUNT_W(16), .COUNT_W(4)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .total_money(total_money),
        .total_price(total_price),
        .count_500(count_500),
        .count_1000(count_1000),
        .count_2000(count_2000),
        .count_5000(count_5000),
        .coin_ready(coin_ready),
        .coin_valid(coin_valid),
        .coin_out(coin_out),
        .change_amount(change_amount),
        .busy(busy),
        .done(done),
        .error(error)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    // Hard stop in case something never terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: actual=%0d required=%0d", name, actual, expected);
    endtask

    // Drives a one-cycle start; returns on the first negedge after acceptance.
    task automatic applyStimulus(input logic [15:0] money, input logic [15:0] price,
                                 input logic [3:0] c0, input logic [3:0] c1,
                                 input logic [3:0] c2, input logic [3:0] c3);
        @(negedge clock);
        total_money = money;
        total_price = price;
        count_500   = c0;
        count_1000  = c1;
        count_2000  = c2;
        count_5000  = c3;
        start       = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    // Greedy change-making with limited stock, computed with plain arithmetic.
    task automatic refModel(input int money, input int price, input int c0, input int c1,
                            input int c2, input int c3, output logic [15:0] expChange,
                            output bit expFail, output logic [127:0] expCoins,
                            output int expCount, output int expLatency);
        int vals[4];
        int stock[4];
        int rem;
        int n;
        int planned;
        vals  = '{5, 10, 20, 50};
        stock = '{c0, c1, c2, c3};
        expCoins = '0;
        planned  = 0;
        if (money < price) begin
            expChange  = 16'd0;
            expFail    = 1'b1;
            expCount   = 0;
            expLatency = 1;
        end else begin
            rem = money - price;
            expChange = 16'(rem);
            for (int d = 3; d >= 0; d--) begin
                n = rem / vals[d];
                if (n > stock[d]) n = stock[d];
                rem = rem - n * vals[d];
                for (int j = 0; j < n; j++) begin
                    expCoins[2*planned +: 2] = 2'(d);
                    planned++;
                end
            end
            expFail    = (rem != 0);
            expCount   = expFail ? 0 : planned;
            expLatency = 5 + planned;
            if (expFail) expCoins = '0;
        end
    endtask

    // Hands out coins with coin_ready high until done, starting at the current negedge.
    task automatic collectCoins(output int n, output logic [127:0] coins,
                                output bit doneSeen, output bit errSeen);
        n = 0;
        coins = '0;
        doneSeen = 1'b0;
        errSeen = 1'b0;
        coin_ready = 1'b1;
        for (int i = 0; i < 60 && !doneSeen; i++) begin
            if (i > 0) @(negedge clock);
            if (coin_valid && n < 64) begin
                coins[2*n +: 2] = coin_out;
                n++;
            end
            if (done) begin
                doneSeen = 1'b1;
                errSeen = error;
            end
        end
    endtask

    task automatic waitValid(output bit found);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (coin_valid) found = 1'b1;
            else @(negedge clock);
        end
    endtask

    // Full request: start, observe every cycle until done, compare against expectations.
    task automatic runTxn(input string name, input logic [15:0] money, input logic [15:0] price,
                          input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                          input logic [3:0] c3, input logic [15:0] expChange, input bit expFail,
                          input logic [127:0] expCoins, input int expCount, input int expLatency,
                          input int readyMode);
        int latency;
        int validCycles;
        int gotCount;
        logic [127:0] gotCoins;
        bit doneSeen;
        bit errSeen;
        bit prevStall;
        bit coinsOk;
        logic [1:0] prevCode;
        logic [15:0] changeSeen;
        latency = 0;
        validCycles = 0;
        gotCount = 0;
        gotCoins = '0;
        doneSeen = 1'b0;
        errSeen = 1'b0;
        prevStall = 1'b0;
        prevCode = 2'b00;
        changeSeen = '0;
        coin_ready = 1'b0;
        applyStimulus(money, price, c0, c1, c2, c3);
        for (int cyc = 1; cyc <= 400 && !doneSeen; cyc++) begin
            if (cyc > 1) @(negedge clock);
            coin_ready = (readyMode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (prevStall) begin
                checkOutput({name, " stall valid held"}, coin_valid, 1);
                checkOutput({name, " stall code held"}, coin_out, prevCode);
            end
            if (latency == 0 && (coin_valid || done)) latency = cyc;
            if (coin_valid) begin
                validCycles++;
                if (coin_ready && gotCount < 64) begin
                    gotCoins[2*gotCount +: 2] = coin_out;
                    gotCount++;
                end
            end
            prevStall = coin_valid && !coin_ready;
            prevCode = coin_out;
            if (done) begin
                doneSeen = 1'b1;
                errSeen = error;
                changeSeen = change_amount;
            end
        end
        checkOutput({name, " done seen"}, doneSeen, 1);
        checkOutput({name, " error"}, errSeen, expFail);
        checkOutput({name, " change_amount"}, changeSeen, expChange);
        checkOutput({name, " latency"}, latency, expLatency);
        checkOutput({name, " coin count"}, gotCount, expCount);
        coinsOk = (gotCount == expCount);
        for (int i = 0; i < gotCount && i < expCount; i++) begin
            if (gotCoins[2*i +: 2] != expCoins[2*i +: 2]) coinsOk = 1'b0;
        end
        checkOutput({name, " coin sequence"}, coinsOk, 1);
        if (expFail) checkOutput({name, " no coin_valid"}, validCycles, 0);
        else if (readyMode == 0) checkOutput({name, " back-to-back"}, validCycles, expCount);
        @(negedge clock);
        coin_ready = 1'b0;
        checkOutput({name, " idle busy"}, busy, 0);
        checkOutput({name, " done one cycle"}, done, 0);
        checkOutput({name, " error one cycle"}, error, 0);
    endtask

    initial begin
        logic [15:0]  mChange;
        bit           mFail;
        logic [127:0] mCoins;
        int           mCount;
        int           mLatency;
        int           n;
        logic [127:0] coins;
        bit           dSeen;
        bit           eSeen;
        bit           found;
        int           money;
        int           price;
        int           s0;
        int           s1;
        int           s2;
        int           s3;

        vecs[0] = '{16'd90,  16'd25, 4'd2,  4'd1, 4'd1, 4'd1, 16'd65, 1'b0, 128'h7,  3,  8};
        vecs[1] = '{16'd40,  16'd10, 4'd4,  4'd1, 4'd0, 4'd0, 16'd30, 1'b0, 128'h1,  5,  10};
        vecs[2] = '{16'd40,  16'd25, 4'd0,  4'd1, 4'd0, 4'd0, 16'd15, 1'b1, 128'h0,  0,  6};
        vecs[3] = '{16'd20,  16'd25, 4'd3,  4'd3, 4'd3, 4'd3, 16'd0,  1'b1, 128'h0,  0,  1};
        vecs[4] = '{16'd50,  16'd50, 4'd1,  4'd1, 4'd1, 4'd1, 16'd0,  1'b0, 128'h0,  0,  5};
        vecs[5] = '{16'd100, 16'd15, 4'd3,  4'd3, 4'd3, 4'd1, 16'd85, 1'b0, 128'h1B, 4,  9};
        vecs[6] = '{16'd60,  16'd0,  4'd0,  4'd0, 4'd3, 4'd1, 16'd60, 1'b1, 128'h0,  0,  6};
        vecs[7] = '{16'd75,  16'd0,  4'd15, 4'd0, 4'd0, 4'd0, 16'd75, 1'b0, 128'h0,  15, 20};

        reset = 1'b1;
        start = 1'b0;
        total_money = '0;
        total_price = '0;
        count_500 = '0;
        count_1000 = '0;
        count_2000 = '0;
        count_5000 = '0;
        coin_ready = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset coin_valid", coin_valid, 0);
        checkOutput("reset coin_out", coin_out, 0);
        checkOutput("reset change_amount", change_amount, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset error", error, 0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            runTxn($sformatf("vec%0d", v), vecs[v].money, vecs[v].price, vecs[v].c0, vecs[v].c1,
                   vecs[v].c2, vecs[v].c3, vecs[v].expChange, vecs[v].expFail, vecs[v].expCoins,
                   vecs[v].expCount, vecs[v].expLatency, 0);
        end

        // Backpressure: hold coin_ready low for three EMIT cycles.
        coin_ready = 1'b0;
        applyStimulus(16'd90, 16'd25, 4'd2, 4'd1, 4'd1, 4'd1);
        waitValid(found);
        checkOutput("bp reach emit", found, 1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp hold valid", coin_valid, 1);
            checkOutput("bp hold code", coin_out, 3);
            @(negedge clock);
        end
        collectCoins(n, coins, dSeen, eSeen);
        checkOutput("bp coin count", n, 3);
        checkOutput("bp coin sequence", coins[31:0], 32'h7);
        checkOutput("bp done", dSeen, 1);
        checkOutput("bp error", eSeen, 0);
        @(negedge clock);
        checkOutput("bp idle busy", busy, 0);

        // Reset while the second coin is being offered.
        coin_ready = 1'b1;
        applyStimulus(16'd90, 16'd25, 4'd2, 4'd1, 4'd1, 4'd1);
        waitValid(found);
        checkOutput("rst reach emit", found, 1);
        @(negedge clock);
        checkOutput("rst second coin valid", coin_valid, 1);
        checkOutput("rst second coin code", coin_out, 1);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("rst coin_valid", coin_valid, 0);
        checkOutput("rst busy", busy, 0);
        checkOutput("rst done", done, 0);
        checkOutput("rst error", error, 0);
        checkOutput("rst change_amount", change_amount, 0);
        reset = 1'b0;
        coin_ready = 1'b0;

        // Start pulses while busy must be ignored.
        applyStimulus(16'd90, 16'd25, 4'd2, 4'd1, 4'd1, 4'd1);
        total_money = 16'd200;
        total_price = 16'd0;
        count_500 = 4'd15;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        waitValid(found);
        checkOutput("ign reach emit", found, 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("ign change_amount", change_amount, 65);
        checkOutput("ign busy", busy, 1);
        checkOutput("ign code", coin_out, 3);
        collectCoins(n, coins, dSeen, eSeen);
        checkOutput("ign coin count", n, 3);
        checkOutput("ign coin sequence", coins[31:0], 32'h7);
        checkOutput("ign done", dSeen, 1);
        checkOutput("ign final change", change_amount, 65);
        @(negedge clock);
        coin_ready = 1'b0;
        checkOutput("ign idle busy", busy, 0);
        @(negedge clock);
        checkOutput("ign no restart", busy, 0);

        // Randomized requests against the reference model, random backpressure.
        for (int t = 0; t < 40; t++) begin
            money = $urandom_range(0, 400);
            price = ($urandom_range(0, 7) == 0) ? money : $urandom_range(0, 300);
            s0 = $urandom_range(0, 15);
            s1 = $urandom_range(0, 15);
            s2 = $urandom_range(0, 15);
            s3 = $urandom_range(0, 15);
            refModel(money, price, s0, s1, s2, s3, mChange, mFail, mCoins, mCount, mLatency);
            runTxn($sformatf("rand%0d", t), 16'(money), 16'(price), 4'(s0), 4'(s1), 4'(s2), 4'(s3),
                   mChange, mFail, mCoins, mCount, mLatency, 1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
